// File: rtl/calc_pkg.sv
// calc_pkg: opcode constants, precedence function and size defaults shared by the calculator stacks
package calc_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    function automatic logic [1:0] prec(input logic [1:0] op);
        return (op == OP_MUL || op == OP_DIV) ? 2'd2 : 2'd1;
    endfunction
endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: DEPTH-entry LIFO; push/pop/din in, combinational top (0 when empty), cnt, full, empty, sticky err out
module lifo_stack #(
    parameter int W = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] ti;
    assign ti = cnt[AW-1:0] - AW'(1);
    assign empty = cnt == '0;
    assign full = cnt == CW'(DEPTH);
    assign top = empty ? '0 : mem[ti];
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (pop && empty) begin
            err <= 1'b1;
        end else if (push && pop) begin
            mem[ti] <= din;
        end else if (pop) begin
            cnt <= cnt - CW'(1);
        end else if (push && full) begin
            err <= 1'b1;
        end else if (push) begin
            mem[cnt[AW-1:0]] <= din;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/calc_stacks.sv
// calc_stacks: operand and operator stacks for an expression evaluator; push/pop/din per stack in, tops, counts, flags, precedence compare and sticky err out
module calc_stacks
    import calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   operand_push,
    input  logic                   operand_pop,
    input  logic [DATA_W-1:0]      operand_din,
    input  logic                   operator_push,
    input  logic                   operator_pop,
    input  logic [1:0]             operator_din,
    output logic [DATA_W-1:0]      operand_top,
    output logic [1:0]             operator_top,
    output logic                   is_lt,
    output logic                   is_empty,
    output logic                   operand_full,
    output logic                   operator_full,
    output logic [$clog2(DEPTH):0] operand_cnt,
    output logic                   err
);
    logic opd_empty, opd_err, opr_err;
    logic [$clog2(DEPTH):0] opr_cnt;
    logic unused;
    assign unused = ^{opd_empty, opr_cnt};
    lifo_stack #(.W(DATA_W), .DEPTH(DEPTH)) u_operand (
        .clk(clk), .rst(rst), .push(operand_push), .pop(operand_pop), .din(operand_din),
        .top(operand_top), .cnt(operand_cnt), .full(operand_full), .empty(opd_empty), .err(opd_err)
    );
    lifo_stack #(.W(2), .DEPTH(DEPTH)) u_operator (
        .clk(clk), .rst(rst), .push(operator_push), .pop(operator_pop), .din(operator_din),
        .top(operator_top), .cnt(opr_cnt), .full(operator_full), .empty(is_empty), .err(opr_err)
    );
    assign err = opd_err | opr_err;
    assign is_lt = !is_empty && (prec(operator_din) <= prec(operator_top));
endmodule

// File: tb/tb_calc_stacks.sv
// tb_calc_stacks: randomized and directed checks of calc_stacks against a queue-based reference model
module tb_calc_stacks;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst, operand_push, operand_pop, operator_push, operator_pop;
    logic [DW-1:0] operand_din;
    logic [1:0] operator_din;
    logic [DW-1:0] operand_top;
    logic [1:0] operator_top;
    logic is_lt, is_empty, operand_full, operator_full, err;
    logic [$clog2(DEPTH):0] operand_cnt;
    int vectors = 0;
    int errs = 0;
    bit started = 0;
    logic [DW-1:0] opd [$];
    logic [1:0] opr [$];
    bit merr = 0;
    always #5 clk = ~clk;
    calc_stacks #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .operand_push(operand_push), .operand_pop(operand_pop),
        .operand_din(operand_din), .operator_push(operator_push), .operator_pop(operator_pop),
        .operator_din(operator_din), .operand_top(operand_top), .operator_top(operator_top),
        .is_lt(is_lt), .is_empty(is_empty), .operand_full(operand_full),
        .operator_full(operator_full), .operand_cnt(operand_cnt), .err(err)
    );
    function automatic int pr(input logic [1:0] op);
        return (op >= 2) ? 2 : 1;
    endfunction
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic model_step(input bit r, input bit pu, input bit po, input logic [DW-1:0] d,
                              input bit opu, input bit opo, input logic [1:0] od);
        if (r) begin
            opd.delete();
            opr.delete();
            merr = 0;
            return;
        end
        if (po && opd.size() == 0) merr = 1;
        else if (pu && po) opd[opd.size()-1] = d;
        else if (po) void'(opd.pop_back());
        else if (pu && opd.size() == DEPTH) merr = 1;
        else if (pu) opd.push_back(d);
        if (opo && opr.size() == 0) merr = 1;
        else if (opu && opo) opr[opr.size()-1] = od;
        else if (opo) void'(opr.pop_back());
        else if (opu && opr.size() == DEPTH) merr = 1;
        else if (opu) opr.push_back(od);
    endtask
    task automatic cyc(input bit r, input bit pu, input bit po, input logic [DW-1:0] d,
                       input bit opu, input bit opo, input logic [1:0] od);
        rst = r; operand_push = pu; operand_pop = po; operand_din = d;
        operator_push = opu; operator_pop = opo; operator_din = od;
        @(posedge clk);
        model_step(r, pu, po, d, opu, opo, od);
        #1;
        started = 1;
    endtask
    task automatic idle();
        cyc(0, 0, 0, 16'h0, 0, 0, 2'b00);
    endtask
    task automatic reset();
        cyc(1, 0, 0, 16'h0, 0, 0, 2'b00);
        rst = 0;
    endtask
    always @(negedge clk) begin
        if (started) begin
            check("operand_top", 32'(operand_top), opd.size() ? 32'(opd[opd.size()-1]) : 32'h0);
            check("operator_top", 32'(operator_top), opr.size() ? 32'(opr[opr.size()-1]) : 32'h0);
            check("operand_cnt", 32'(operand_cnt), 32'(opd.size()));
            check("is_empty", 32'(is_empty), 32'(opr.size() == 0));
            check("operand_full", 32'(operand_full), 32'(opd.size() == DEPTH));
            check("operator_full", 32'(operator_full), 32'(opr.size() == DEPTH));
            check("err", 32'(err), 32'(merr));
            check("is_lt", 32'(is_lt),
                  32'(opr.size() != 0 && pr(operator_din) <= pr(opr[opr.size()-1])));
        end
    end
    initial begin
        reset();
        check("rst_cnt", 32'(operand_cnt), 0);
        check("rst_empty", 32'(is_empty), 1);
        check("rst_err", 32'(err), 0);
        check("rst_top", 32'(operand_top), 0);
        check("rst_is_lt", 32'(is_lt), 0);
        check("rst_full", 32'(operand_full), 0);
        cyc(0, 1, 0, 16'd5, 0, 0, 2'b00);
        cyc(0, 1, 0, 16'd7, 0, 0, 2'b00);
        cyc(0, 1, 0, 16'd9, 0, 0, 2'b00);
        check("push3_top", 32'(operand_top), 9);
        check("push3_cnt", 32'(operand_cnt), 3);
        cyc(0, 0, 1, 16'd0, 0, 0, 2'b00);
        check("pop_top", 32'(operand_top), 7);
        check("pop_cnt", 32'(operand_cnt), 2);
        reset();
        cyc(0, 1, 0, 16'd3, 0, 0, 2'b00);
        cyc(0, 1, 0, 16'd4, 0, 0, 2'b00);
        cyc(0, 1, 1, 16'd12, 0, 0, 2'b00);
        check("replace_top", 32'(operand_top), 12);
        check("replace_cnt", 32'(operand_cnt), 2);
        cyc(0, 1, 0, 16'd6, 0, 1, 2'b00);
        check("pre_rst_err", 32'(err), 1);
        check("pre_rst_cnt", 32'(operand_cnt), 3);
        cyc(1, 1, 0, 16'd8, 0, 0, 2'b00);
        rst = 0;
        check("rst_push_cnt", 32'(operand_cnt), 0);
        check("rst_push_empty", 32'(is_empty), 1);
        check("rst_push_err", 32'(err), 0);
        reset();
        cyc(0, 0, 0, 16'd0, 0, 1, 2'b00);
        check("opr_underflow_err", 32'(err), 1);
        check("opr_underflow_empty", 32'(is_empty), 1);
        cyc(0, 0, 0, 16'd0, 1, 1, 2'b10);
        check("opr_pushpop_empty", 32'(is_empty), 1);
        check("opr_pushpop_top", 32'(operator_top), 0);
        reset();
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 16'(10 + i), 0, 0, 2'b00);
        check("fill_full", 32'(operand_full), 1);
        check("fill_err", 32'(err), 0);
        cyc(0, 1, 0, 16'd99, 0, 0, 2'b00);
        check("ovf_full", 32'(operand_full), 1);
        check("ovf_top", 32'(operand_top), 17);
        check("ovf_err", 32'(err), 1);
        idle();
        idle();
        check("ovf_err_sticky", 32'(err), 1);
        reset();
        cyc(0, 0, 0, 16'd0, 1, 0, 2'b10);
        operator_din = 2'b00;
        #1 check("mul_vs_add", 32'(is_lt), 1);
        operator_din = 2'b11;
        #1 check("mul_vs_div", 32'(is_lt), 1);
        reset();
        cyc(0, 0, 0, 16'd0, 1, 0, 2'b00);
        operator_din = 2'b10;
        #1 check("add_vs_mul", 32'(is_lt), 0);
        operator_din = 2'b01;
        #1 check("add_vs_sub", 32'(is_lt), 1);
        reset();
        operator_din = 2'b00;
        #1 check("empty_is_lt", 32'(is_lt), 0);
        for (int blk = 0; blk < 40; blk++) begin
            int pw = (blk % 2) ? 30 : 75;
            for (int k = 0; k < 60; k++) begin
                bit r = ($urandom_range(0, 199) == 0);
                bit pu = ($urandom_range(0, 99) < pw);
                bit po = ($urandom_range(0, 99) < 100 - pw);
                bit opu = ($urandom_range(0, 99) < pw);
                bit opo = ($urandom_range(0, 99) < 100 - pw);
                cyc(r, pu, po, 16'($urandom), opu, opo, 2'($urandom));
            end
        end
        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
